// File: rtl/data_memory_param.sv
// rtl/data_memory_param.sv - parametrised data memory with byte-lane writes, registered read and clear sweep
// One-port synchronous array; write-first merge and out-of-range handling sit outside the array.
module data_memory_param #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rd_dm_en,
   input  logic                wr_dm_en,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   wr_dm_data,
   input  logic [DATA_W/8-1:0] wr_dm_be,
   input  logic                clr_start,
   output logic [DATA_W-1:0]   rd_dm_data,
   output logic                rd_valid,
   output logic                busy,
   output logic                addr_err
);

   localparam int NB = DATA_W / 8;
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t              state, state_next;
   logic [ADDR_W-1:0]   ptr, ptr_next;

   logic                in_range;
   logic                idle;
   logic                rd_acc;
   logic                wr_acc;
   logic                ram_re;

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [NB-1:0]       mem_be;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   ram_q;

   logic                rd_pend;
   logic                rd_oor;
   logic [NB-1:0]       byp_be;
   logic [DATA_W-1:0]   byp_data;
   logic [DATA_W-1:0]   rd_hold;
   logic [DATA_W-1:0]   merged;

   assign in_range = {1'b0, dm_addr} < DEPTH_X;
   assign idle     = (state == S_IDLE);
   assign rd_acc   = idle && rd_dm_en;
   assign wr_acc   = idle && wr_dm_en;
   assign ram_re   = rd_acc && in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      case (state)
         S_IDLE: begin
            if (clr_start) begin
               state_next = S_CLEAR;
               ptr_next   = '0;
            end
         end
         S_CLEAR: begin
            if (ptr == LAST) begin
               state_next = S_IDLE;
               ptr_next   = '0;
            end else begin
               ptr_next = ptr + 1'b1;
            end
         end
         default: begin
            state_next = S_CLEAR;
            ptr_next   = '0;
         end
      endcase
   end

   // The sweep owns the array write port while busy; user writes are only taken when idle.
   always_comb begin
      busy      = (state == S_CLEAR);
      mem_we    = 1'b0;
      mem_addr  = dm_addr;
      mem_wdata = wr_dm_data;
      mem_be    = wr_dm_be;
      if (busy) begin
         mem_we    = 1'b1;
         mem_addr  = ptr;
         mem_wdata = '0;
         mem_be    = '1;
      end else begin
         mem_we = wr_dm_en && in_range;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
      if (ram_re) ram_q <= mem[dm_addr];
   end

   // The array reads old data on a collision; enabled lanes of the same-cycle write are patched in here.
   always_comb begin
      merged = '0;
      if (!rd_oor) begin
         for (int i = 0; i < NB; i++) begin
            merged[8*i +: 8] = byp_be[i] ? byp_data[8*i +: 8] : ram_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend  <= 1'b0;
         rd_oor   <= 1'b0;
         byp_be   <= '0;
         byp_data <= '0;
         addr_err <= 1'b0;
         rd_hold  <= '0;
      end else begin
         rd_pend  <= rd_acc;
         rd_oor   <= !in_range;
         byp_be   <= (wr_acc && in_range) ? wr_dm_be : '0;
         byp_data <= wr_dm_data;
         addr_err <= (rd_acc || wr_acc) && !in_range;
         if (rd_pend) rd_hold <= merged;
      end
   end

   assign rd_dm_data = rd_pend ? merged : rd_hold;
   assign rd_valid   = rd_pend;

endmodule

// File: tb/tb_data_memory_param.sv
// tb/tb_data_memory_param.sv - directed self-checking bench for data_memory_param (DEPTH 64 and 48)
// Both instances share stimulus; each check targets the instance the vector is meant for.
module tb_data_memory_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_dm_en;
   logic        wr_dm_en;
   logic [5:0]  dm_addr;
   logic [15:0] wr_dm_data;
   logic [1:0]  wr_dm_be;
   logic        clr_start;

   logic [15:0] rd_data64, rd_data48;
   logic        valid64, valid48;
   logic        busy64, busy48;
   logic        err64, err48;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_memory_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .rd_dm_en(rd_dm_en), .wr_dm_en(wr_dm_en),
      .dm_addr(dm_addr), .wr_dm_data(wr_dm_data), .wr_dm_be(wr_dm_be),
      .clr_start(clr_start), .rd_dm_data(rd_data64), .rd_valid(valid64),
      .busy(busy64), .addr_err(err64)
   );

   data_memory_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(48)) u_dut48 (
      .clk(clk), .rst_n(rst_n), .rd_dm_en(rd_dm_en), .wr_dm_en(wr_dm_en),
      .dm_addr(dm_addr), .wr_dm_data(wr_dm_data), .wr_dm_be(wr_dm_be),
      .clr_start(clr_start), .rd_dm_data(rd_data48), .rd_valid(valid48),
      .busy(busy48), .addr_err(err48)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rd_dm_en   = 1'b0;
      wr_dm_en   = 1'b0;
      clr_start  = 1'b0;
      dm_addr    = '0;
      wr_dm_data = '0;
      wr_dm_be   = '0;
   endtask

   task automatic do_write(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_dm_en = 1'b1; dm_addr = a; wr_dm_data = d; wr_dm_be = be;
      step();
      idle_inputs();
   endtask

   task automatic do_read(input logic [5:0] a);
      rd_dm_en = 1'b1; dm_addr = a;
      step();
      idle_inputs();
   endtask

   // Steps until both instances leave busy; a count of -1 means the bound expired.
   task automatic wait_clear(output int c64, output int c48);
      c64 = -1;
      c48 = -1;
      for (int n = 1; n <= 200; n++) begin
         step();
         if (!busy48 && c48 < 0) c48 = n;
         if (!busy64) begin
            c64 = n;
            break;
         end
      end
   endtask

   initial begin
      int c64, c48;
      logic spur;

      idle_inputs();
      rst_n = 1'b0;
      repeat (3) step();
      check("reset_busy64", busy64, 1);
      check("reset_busy48", busy48, 1);
      check("reset_valid", valid64, 0);
      check("reset_data", rd_data64, 0);
      check("reset_err", err64, 0);

      rst_n = 1'b1;
      wait_clear(c64, c48);
      check("clear_len64", c64, 64);
      check("clear_len48", c48, 48);

      for (int i = 0; i < 64; i++) begin
         rd_dm_en = 1'b1; dm_addr = 6'(i);
         step();
         check($sformatf("init_zero_%0d", i), rd_data64, 0);
         check($sformatf("init_valid_%0d", i), valid64, 1);
      end
      idle_inputs();
      step();
      check("valid_drop", valid64, 0);

      do_write(6'd5, 16'd1000, 2'b11);
      do_write(6'd6, 16'd2000, 2'b11);
      rd_dm_en = 1'b1; dm_addr = 6'd5;
      step();
      check("b2b_rd5", rd_data64, 16'd1000);
      check("b2b_v5", valid64, 1);
      dm_addr = 6'd6;
      step();
      check("b2b_rd6", rd_data64, 16'd2000);
      check("b2b_v6", valid64, 1);
      idle_inputs();
      step();
      check("hold_data", rd_data64, 16'd2000);
      check("hold_valid", valid64, 0);

      do_write(6'd7, 16'hABCD, 2'b11);
      do_write(6'd7, 16'h1234, 2'b01);
      do_read(6'd7);
      check("lane_lo", rd_data64, 16'hAB34);
      do_write(6'd7, 16'hFFFF, 2'b00);
      do_read(6'd7);
      check("lane_none", rd_data64, 16'hAB34);

      rd_dm_en = 1'b1; wr_dm_en = 1'b1; dm_addr = 6'd8; wr_dm_data = 16'd4000; wr_dm_be = 2'b11;
      step();
      idle_inputs();
      check("wfirst_data", rd_data64, 16'd4000);
      check("wfirst_valid", valid64, 1);
      rd_dm_en = 1'b1; wr_dm_en = 1'b1; dm_addr = 6'd7; wr_dm_data = 16'h5566; wr_dm_be = 2'b10;
      step();
      idle_inputs();
      check("wfirst_merge", rd_data64, 16'h5534);

      do_write(6'd50, 16'h7777, 2'b11);
      check("oor_wr_err48", err48, 1);
      check("oor_wr_err64", err64, 0);
      check("oor_wr_nov48", valid48, 0);
      step();
      check("oor_err_pulse", err48, 0);
      do_read(6'd50);
      check("oor_rd_valid48", valid48, 1);
      check("oor_rd_data48", rd_data48, 0);
      check("oor_rd_err48", err48, 1);
      check("inrange_rd64", rd_data64, 16'h7777);
      do_read(6'd2);
      check("alias2_48", rd_data48, 0);
      do_read(6'd18);
      check("alias18_48", rd_data48, 0);
      do_read(6'd5);
      check("d48_rd5", rd_data48, 16'd1000);

      clr_start = 1'b1; rd_dm_en = 1'b1; dm_addr = 6'd5;
      step();
      idle_inputs();
      check("clr_rd_served", rd_data64, 16'd1000);
      check("clr_rd_valid", valid64, 1);
      check("clr_busy", busy64, 1);
      spur = 1'b0;
      c64 = -1;
      c48 = -1;
      for (int n = 1; n <= 200; n++) begin
         rd_dm_en   = (n == 6);
         wr_dm_en   = (n == 6);
         clr_start  = (n == 6);
         dm_addr    = 6'd0;
         wr_dm_data = 16'h9999;
         wr_dm_be   = 2'b11;
         step();
         if (n == 6) spur = valid64 | valid48 | err64 | err48;
         if (!busy48 && c48 < 0) c48 = n;
         if (!busy64) begin
            c64 = n;
            break;
         end
      end
      idle_inputs();
      check("busy_no_response", spur, 0);
      check("reclear_len64", c64, 64);
      check("reclear_len48", c48, 48);
      do_read(6'd0);
      check("busy_wr_ignored", rd_data64, 0);
      do_read(6'd7);
      check("cleared_7", rd_data64, 0);

      do_write(6'd30, 16'h3030, 2'b11);
      do_read(6'd30);
      check("pre_rst_30", rd_data64, 16'h3030);
      clr_start = 1'b1;
      step();
      idle_inputs();
      repeat (20) step();
      rst_n = 1'b0;
      step();
      check("midrst_busy", busy64, 1);
      check("midrst_valid", valid64, 0);
      rst_n = 1'b1;
      wait_clear(c64, c48);
      check("rst_clear_len64", c64, 64);
      check("rst_clear_len48", c48, 48);
      do_read(6'd30);
      check("post_rst_30_64", rd_data64, 0);
      check("post_rst_30_48", rd_data48, 0);
      do_read(6'd63);
      check("post_rst_63", rd_data64, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
